// File: rtl/spi_reg_sequencer.sv
// Sensor register read/write sequencer in front of spi_master: owns chip-select timing,
// streams command and data bytes through the start/busy/new_data handshake, packs read bytes.
module spi_reg_sequencer #(
    parameter int unsigned MAX_BYTES       = 6,
    parameter int unsigned CS_SETUP_CYCLES = 4,
    parameter int unsigned CS_HOLD_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   rd_wr,
    input  logic [6:0]             reg_addr,
    input  logic [7:0]             wr_data,
    input  logic [2:0]             nbytes,
    output logic                   spi_start,
    output logic [7:0]             spi_data_in,
    input  logic                   spi_busy,
    input  logic                   spi_new_data,
    input  logic [7:0]             spi_data_out,
    output logic                   cs_n,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [8*MAX_BYTES-1:0] rd_data
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StSend  = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StHold  = 3'd4;
    localparam logic [2:0] StFin   = 3'd5;
    localparam logic [2:0] StAbort = 3'd6;

    logic [2:0]             state_q, state_d;
    logic [15:0]            cnt_q;
    logic [15:0]            tmo_q;
    logic [3:0]             idx_q;    // byte in flight, 0 = command byte
    logic [3:0]             len_q;    // data bytes following the command byte
    logic                   rd_q;
    logic [6:0]             addr_q;
    logic [7:0]             wdata_q;
    logic [8*MAX_BYTES-1:0] shadow_q;
    logic [3:0]             len_req;

    always_comb begin
        if (nbytes == 3'd0) begin
            len_req = 4'd1;
        end else if ({1'b0, nbytes} > 4'(MAX_BYTES)) begin
            len_req = 4'(MAX_BYTES);
        end else begin
            len_req = {1'b0, nbytes};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req) state_d = StSetup;
            StSetup: if (cnt_q == 16'(CS_SETUP_CYCLES - 1)) state_d = StSend;
            StSend:  if (!spi_busy) state_d = StWait;
            StWait: begin
                // Data arriving on the timeout cycle still completes the byte.
                if (spi_new_data) begin
                    state_d = (idx_q == len_q) ? StHold : StSend;
                end else if (tmo_q == 16'(TIMEOUT_CYCLES)) begin
                    state_d = StAbort;
                end
            end
            StHold:  if (cnt_q == 16'(CS_HOLD_CYCLES - 1)) state_d = StFin;
            default: state_d = StIdle;
        endcase
    end

    assign cs_n = !(state_q == StSetup || state_q == StSend ||
                    state_q == StWait  || state_q == StHold);
    assign busy = (state_q != StIdle);
    assign done = (state_q == StFin) || (state_q == StAbort);
    assign err  = (state_q == StAbort);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            tmo_q       <= 16'd0;
            idx_q       <= 4'd0;
            len_q       <= 4'd0;
            rd_q        <= 1'b0;
            addr_q      <= 7'd0;
            wdata_q     <= 8'd0;
            shadow_q    <= '0;
            spi_start   <= 1'b0;
            spi_data_in <= 8'd0;
            rd_data     <= '0;
        end else begin
            state_q   <= state_d;
            spi_start <= 1'b0;
            cnt_q     <= (state_d == state_q) ? cnt_q + 16'd1 : 16'd0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        rd_q     <= rd_wr;
                        addr_q   <= reg_addr;
                        wdata_q  <= wr_data;
                        len_q    <= rd_wr ? len_req : 4'd1;
                        idx_q    <= 4'd0;
                        shadow_q <= '0;
                    end
                end
                StSend: begin
                    if (!spi_busy) begin
                        spi_start   <= 1'b1;
                        spi_data_in <= (idx_q == 4'd0) ? {rd_q, addr_q} :
                                       (rd_q ? 8'h00 : wdata_q);
                        tmo_q       <= 16'd0;
                    end
                end
                StWait: begin
                    if (spi_new_data) begin
                        if (rd_q) begin
                            for (int k = 0; k < int'(MAX_BYTES); k++) begin
                                if (idx_q == 4'(k + 1)) shadow_q[8*k +: 8] <= spi_data_out;
                            end
                        end
                        idx_q <= idx_q + 4'd1;
                    end else if (tmo_q != 16'(TIMEOUT_CYCLES)) begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                StFin: begin
                    if (rd_q) rd_data <= shadow_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer with a small spi_master responder model.
module tb_spi_reg_sequencer;

    localparam int unsigned TMO = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        rd_wr = 1'b0;
    logic [6:0]  reg_addr = 7'd0;
    logic [7:0]  wr_data = 8'd0;
    logic [2:0]  nbytes = 3'd0;
    logic        spi_start;
    logic [7:0]  spi_data_in;
    logic        spi_busy;
    logic        spi_new_data = 1'b0;
    logic [7:0]  spi_data_out = 8'd0;
    logic        cs_n, busy, done, err;
    logic [47:0] rd_data;

    spi_reg_sequencer #(
        .MAX_BYTES      (6),
        .CS_SETUP_CYCLES(4),
        .CS_HOLD_CYCLES (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .rd_wr       (rd_wr),
        .reg_addr    (reg_addr),
        .wr_data     (wr_data),
        .nbytes      (nbytes),
        .spi_start   (spi_start),
        .spi_data_in (spi_data_in),
        .spi_busy    (spi_busy),
        .spi_new_data(spi_new_data),
        .spi_data_out(spi_data_out),
        .cs_n        (cs_n),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    // spi_master stand-in: busy for a few clocks per byte, then new_data with the next response.
    logic [7:0] resp_q[$];
    bit         mute = 1'b0;
    bit         busy_force = 1'b0;
    bit         m_active = 1'b0;
    int         m_cnt = 0;
    assign spi_busy = m_active | busy_force;

    always @(posedge clk) begin
        spi_new_data <= 1'b0;
        if (rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else if (m_active) begin
            if (m_cnt == 1) begin
                m_active <= 1'b0;
                if (!mute) begin
                    spi_new_data <= 1'b1;
                    if (resp_q.size() > 0) spi_data_out <= resp_q.pop_front();
                    else spi_data_out <= 8'h00;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (spi_start) begin
            m_active <= 1'b1;
            m_cnt    <= 3;
        end
    end

    int         ncyc = 0, start_cnt = 0, start_busy = 0, done_cnt = 0, fall_cnt = 0;
    int         last_nd = 0, last_start = 0, rise_cyc = 0, done_cyc = 0;
    logic       cs_prev = 1'b1;
    logic [7:0] sent[$];

    always @(negedge clk) begin
        ncyc++;
        if (spi_new_data) last_nd = ncyc;
        if (spi_start) begin
            start_cnt++;
            last_start = ncyc;
            sent.push_back(spi_data_in);
            if (spi_busy) start_busy++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        if (cs_n && !cs_prev) rise_cyc = ncyc;
        if (!cs_n && cs_prev) fall_cnt++;
        cs_prev = cs_n;
    end

    int passed = 0, total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input bit rw, input logic [6:0] a, input logic [7:0] d,
                         input logic [2:0] n);
        rd_wr = rw; reg_addr = a; wr_data = d; nbytes = n; req = 1'b1;
        tick;
        req = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!spi_start && n < 200) begin
            tick;
            n++;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            tick;
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    int b, s0, d0, f0, n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        repeat (3) tick;
        check("rst_cs_n", cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_spi_data_in", spi_data_in, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        repeat (2) tick;

        // Read of 2 bytes from 0x2A
        resp_q.push_back(8'h11); resp_q.push_back(8'hA5); resp_q.push_back(8'h3C);
        b = sent.size(); s0 = start_cnt; d0 = done_cnt; f0 = fall_cnt;
        issue(1'b1, 7'h2A, 8'h00, 3'd2);
        check("rd2_busy_after_req", busy, 1);
        check("rd2_cs_low_after_req", cs_n, 0);
        wait_start(n);
        check("rd2_setup_latency", n, 5);
        wait_done("rd2");
        check("rd2_err", err, 0);
        check("rd2_cs_high_fin", cs_n, 1);
        tick;
        check("rd2_rd_data", rd_data, 48'h0000_0000_3CA5);
        check("rd2_busy_idle", busy, 0);
        check("rd2_starts", start_cnt - s0, 3);
        check("rd2_byte0", sent[b], 8'hAA);
        check("rd2_byte1", sent[b+1], 8'h00);
        check("rd2_byte2", sent[b+2], 8'h00);
        check("rd2_done_count", done_cnt - d0, 1);
        check("rd2_cs_falls", fall_cnt - f0, 1);
        check("rd2_hold_latency", rise_cyc - last_nd, 5);

        // Write 0x7E to 0x10; nbytes is ignored
        resp_q.push_back(8'hEE); resp_q.push_back(8'hDD);
        b = sent.size(); s0 = start_cnt;
        issue(1'b0, 7'h10, 8'h7E, 3'd5);
        wait_done("wr");
        check("wr_err", err, 0);
        tick;
        check("wr_rd_data_kept", rd_data, 48'h0000_0000_3CA5);
        check("wr_starts", start_cnt - s0, 2);
        check("wr_byte0", sent[b], 8'h10);
        check("wr_byte1", sent[b+1], 8'h7E);

        // nbytes = 0 behaves as 1
        resp_q.push_back(8'h99); resp_q.push_back(8'h5A);
        s0 = start_cnt;
        issue(1'b1, 7'h05, 8'h00, 3'd0);
        wait_done("len0");
        tick;
        check("len0_starts", start_cnt - s0, 2);
        check("len0_rd_data", rd_data, 48'h0000_0000_005A);

        // nbytes = 7 clamps to 6
        resp_q.push_back(8'hFF);
        for (int i = 1; i <= 6; i++) resp_q.push_back(8'(i));
        b = sent.size(); s0 = start_cnt;
        issue(1'b1, 7'h06, 8'h00, 3'd7);
        wait_done("len7");
        tick;
        check("len7_starts", start_cnt - s0, 7);
        check("len7_byte0", sent[b], 8'h86);
        check("len7_rd_data", rd_data, 48'h0605_0403_0201);

        // Timeout: responder never returns data
        mute = 1'b1;
        s0 = start_cnt;
        issue(1'b1, 7'h01, 8'h00, 3'd1);
        wait_done("tmo");
        check("tmo_err", err, 1);
        check("tmo_cs_n", cs_n, 1);
        check("tmo_latency", done_cyc - last_start, TMO + 1);
        check("tmo_starts", start_cnt - s0, 1);
        tick;
        check("tmo_rd_data_kept", rd_data, 48'h0605_0403_0201);
        check("tmo_busy_idle", busy, 0);
        mute = 1'b0;
        resp_q.push_back(8'h44); resp_q.push_back(8'h55);
        issue(1'b0, 7'h22, 8'h33, 3'd0);
        wait_done("after_tmo");
        check("after_tmo_err", err, 0);

        // Busy handling: extra requests ignored, start held off by spi_busy
        tick;
        busy_force = 1'b1;
        resp_q.push_back(8'h00); resp_q.push_back(8'h77);
        b = sent.size(); s0 = start_cnt; d0 = done_cnt;
        issue(1'b1, 7'h2A, 8'h00, 3'd1);
        check("bsy_cs_low", cs_n, 0);
        rd_wr = 1'b0; reg_addr = 7'h7F; wr_data = 8'hC3; req = 1'b1;
        tick;
        req = 1'b0;
        repeat (14) tick;
        check("bsy_no_start_while_busy", start_cnt - s0, 0);
        busy_force = 1'b0;
        wait_start(n);
        check("bsy_start_after_release", n, 1);
        rd_wr = 1'b0; reg_addr = 7'h7F; req = 1'b1;
        tick;
        req = 1'b0;
        wait_done("bsy");
        tick;
        check("bsy_rd_data", rd_data, 48'h0000_0000_0077);
        check("bsy_byte0", sent[b], 8'hAA);
        check("bsy_byte1", sent[b+1], 8'h00);
        repeat (10) tick;
        check("bsy_starts", start_cnt - s0, 2);
        check("bsy_single_done", done_cnt - d0, 1);
        check("bsy_idle", busy, 0);
        check("start_never_while_busy", start_busy, 0);

        // Reset during WAIT of byte 1
        resp_q.push_back(8'h11); resp_q.push_back(8'h22); resp_q.push_back(8'h33);
        s0 = start_cnt;
        issue(1'b1, 7'h2A, 8'h00, 3'd2);
        n = 0;
        while (start_cnt - s0 < 2 && n < 200) begin
            tick;
            n++;
        end
        check("mid_rst_reached_byte1", start_cnt - s0, 2);
        d0 = done_cnt;
        rst = 1'b1;
        tick;
        check("mid_rst_cs_n", cs_n, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_spi_data_in", spi_data_in, 0);
        rst = 1'b0;
        repeat (20) tick;
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_stays_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
